// File: rtl/timer_irq.sv
// ============================================================================
//  Module   : timer_irq
//  Function : Memory-mapped countdown timer that raises an interrupt on expiry.
//             Optional build macro TIMER_COUNT_WRITE_EN makes COUNT writable.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module timer_irq #(
   parameter int CNT_W = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:2] Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_CNT  = 2'd2,
      S_INT  = 2'd3
   } state_t;

   localparam logic [1:0] c_ADDR_CTRL   = 2'd0;
   localparam logic [1:0] c_ADDR_PRESET = 2'd1;
   localparam logic [1:0] c_ADDR_COUNT  = 2'd2;
   localparam logic [1:0] c_MODE_PERIOD = 2'd1;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_en;
   logic [1:0]       r_mode;
   logic             r_im;
   logic             r_flag;
   logic [CNT_W-1:0] r_preset;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_nxt;
   logic             w_flag_set;
   logic             w_flag_clr;
   logic             w_en_clr;
   logic             w_wr_ctrl;
   logic             w_wr_preset;
   logic             w_wr_count;
   logic [31:0]      w_preset_ext;
   logic [31:0]      w_count_ext;
   logic             w_unused_bits;

   assign w_wr_ctrl   = WE && (Addr[3:2] == c_ADDR_CTRL);
   assign w_wr_preset = WE && (Addr[3:2] == c_ADDR_PRESET);
`ifdef TIMER_COUNT_WRITE_EN
   assign w_wr_count  = WE && (Addr[3:2] == c_ADDR_COUNT);
`else
   assign w_wr_count  = 1'b0;
`endif
   assign w_unused_bits = ^{Addr[31:4], Din};

   assign IRQ = r_im & r_flag;

   // Next-state logic; a same-cycle CTRL write with EN=0 freezes COUNT at once.
   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_flag_set  = 1'b0;
      w_flag_clr  = 1'b0;
      w_en_clr    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_en) w_state_nxt = S_LOAD;
         end
         S_LOAD: begin
            w_count_nxt = r_preset;
            w_state_nxt = S_CNT;
         end
         S_CNT: begin
            if (!r_en || (w_wr_ctrl && !Din[0])) begin
               w_state_nxt = S_IDLE;
            end else if (r_count > CNT_W'(1)) begin
               w_count_nxt = r_count - CNT_W'(1);
            end else begin
               w_count_nxt = '0;
               w_flag_set  = 1'b1;
               w_state_nxt = S_INT;
            end
         end
         S_INT: begin
            if (r_mode == c_MODE_PERIOD) w_flag_clr = 1'b1;
            else                         w_en_clr   = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_en     <= 1'b0;
         r_mode   <= 2'd0;
         r_im     <= 1'b0;
         r_flag   <= 1'b0;
         r_preset <= '0;
         r_count  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_wr_count ? Din[CNT_W-1:0] : w_count_nxt;
         // Bus write to CTRL overrides the FSM clearing EN in the same cycle.
         if (w_wr_ctrl) begin
            r_en   <= Din[0];
            r_mode <= Din[2:1];
            r_im   <= Din[3];
         end else if (w_en_clr) begin
            r_en <= 1'b0;
         end
         if (w_wr_preset) r_preset <= Din[CNT_W-1:0];
         if (w_wr_ctrl || w_wr_preset || w_flag_clr) r_flag <= 1'b0;
         else if (w_flag_set)                        r_flag <= 1'b1;
      end
   end

   always_comb begin
      w_preset_ext = '0;
      w_count_ext  = '0;
      w_preset_ext[CNT_W-1:0] = r_preset;
      w_count_ext[CNT_W-1:0]  = r_count;
   end

   always_comb begin
      Dout = 32'd0;
      case (Addr[3:2])
         c_ADDR_CTRL:   Dout = {28'd0, r_im, r_mode, r_en};
         c_ADDR_PRESET: Dout = w_preset_ext;
         c_ADDR_COUNT:  Dout = w_count_ext;
         default:       Dout = 32'd0;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_timer_irq.sv
// ============================================================================
//  Module   : tb_timer_irq
//  Function : Scoreboard bench for timer_irq (register access, modes, masking).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_timer_irq;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:2] Addr = '0;
   logic        WE = 1'b0;
   logic [31:0] Din = '0;
   logic [31:0] Dout;
   logic        IRQ;

   timer_irq #(.CNT_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .Addr  (Addr),
      .WE    (WE),
      .Din   (Din),
      .Dout  (Dout),
      .IRQ   (IRQ)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

`ifdef TIMER_COUNT_WRITE_EN
   localparam bit c_CNT_WR = 1'b1;
`else
   localparam bit c_CNT_WR = 1'b0;
`endif

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb_q.push_back(e);
   endtask

   task automatic pop_cmp(input logic [31:0] obs);
      exp_t e;
      e = sb_q.pop_front();
      check_val(e.tag, obs, e.val);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      Addr = {28'd0, a};
      Din  = d;
      WE   = 1'b1;
      tick();
      WE   = 1'b0;
      Din  = '0;
   endtask

   task automatic rd_chk(input logic [1:0] a, input string tag, input logic [31:0] exp);
      Addr = {28'd0, a};
      #1;
      push_exp(tag, exp);
      pop_cmp(Dout);
   endtask

   task automatic irq_chk(input string tag, input logic exp);
      push_exp(tag, {31'd0, exp});
      pop_cmp({31'd0, IRQ});
   endtask

   task automatic wait_count(input logic [31:0] val, input int bound);
      bit found = 1'b0;
      Addr = {28'd0, 2'd2};
      for (int i = 0; i < bound && !found; i++) begin
         #1;
         if (Dout == val) found = 1'b1;
         else tick();
      end
      if (!found) check_val("wait_count_timeout", Dout, val);
   endtask

   initial begin
      logic [31:0] per_cnt [6];
      per_cnt[0] = 3; per_cnt[1] = 2; per_cnt[2] = 1;
      per_cnt[3] = 0; per_cnt[4] = 0; per_cnt[5] = 0;

      // Reset state and plain register access
      repeat (3) tick();
      reset = 1'b0;
      rd_chk(2'd0, "rst_ctrl", 32'd0);
      rd_chk(2'd1, "rst_preset", 32'd0);
      rd_chk(2'd2, "rst_count", 32'd0);
      irq_chk("rst_irq", 1'b0);
      wr(2'd1, 32'd5);
      rd_chk(2'd1, "preset_rd", 32'd5);
      wr(2'd3, 32'hDEAD_BEEF);
      rd_chk(2'd3, "unmapped_rd", 32'd0);
      wr(2'd0, 32'hFFFF_FFF8);
      rd_chk(2'd0, "ctrl_upper_bits", 32'h8);
      wr(2'd0, 32'd0);

      // One-shot level, P=5: IRQ first high in cycle P+3 after the write edge
      wr(2'd1, 32'd5);
      wr(2'd0, 32'h9);
      for (int k = 1; k <= 8; k++) begin
         irq_chk($sformatf("m0_irq_c%0d", k), (k == 8));
         if (k < 8) tick();
      end
      repeat (3) tick();
      irq_chk("m0_irq_hold", 1'b1);
      rd_chk(2'd0, "m0_ctrl_en_clr", 32'h8);
      wr(2'd1, 32'd5);
      irq_chk("m0_irq_drop", 1'b0);

      // PRESET=0 expires like PRESET=1
      wr(2'd1, 32'd0);
      wr(2'd0, 32'h9);
      for (int k = 1; k <= 4; k++) begin
         irq_chk($sformatf("p0_irq_c%0d", k), (k == 4));
         if (k < 4) tick();
      end
      wr(2'd0, 32'd0);

      // Periodic pulse, P=3: period 6, COUNT 3,2,1,0,0,0
      wr(2'd1, 32'd3);
      wr(2'd0, 32'hB);
      Addr = {28'd0, 2'd2};
      for (int k = 1; k <= 20; k++) begin
         if (k >= 3) begin
            #1;
            push_exp($sformatf("m1_count_c%0d", k), per_cnt[(k - 3) % 6]);
            pop_cmp(Dout);
            irq_chk($sformatf("m1_irq_c%0d", k), ((k - 3) % 6 == 3));
         end
         tick();
      end
      wr(2'd0, 32'd0);

      // Masked expiry
      wr(2'd1, 32'd2);
      wr(2'd0, 32'h1);
      for (int k = 1; k <= 8; k++) begin
         irq_chk($sformatf("mask_irq_c%0d", k), 1'b0);
         tick();
      end
      rd_chk(2'd0, "mask_ctrl", 32'h0);

      // Mid-count disable, re-enable reload, then reset mid-count
      wr(2'd1, 32'd10);
      wr(2'd0, 32'h1);
      wait_count(32'd6, 30);
      wr(2'd0, 32'd0);
      rd_chk(2'd2, "freeze_count", 32'd6);
      repeat (3) tick();
      rd_chk(2'd2, "freeze_hold", 32'd6);
      wr(2'd0, 32'h1);
      tick();
      tick();
      rd_chk(2'd2, "reload_count", 32'd10);
      repeat (2) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      rd_chk(2'd0, "mrst_ctrl", 32'd0);
      rd_chk(2'd1, "mrst_preset", 32'd0);
      rd_chk(2'd2, "mrst_count", 32'd0);
      irq_chk("mrst_irq", 1'b0);

      // COUNT write (honoured only with the build macro)
      wr(2'd1, 32'd60);
      wr(2'd0, 32'h9);
      wait_count(32'd50, 40);
      wr(2'd2, 32'd2);
      rd_chk(2'd2, "cntwr_c1", c_CNT_WR ? 32'd2 : 32'd49);
      tick();
      rd_chk(2'd2, "cntwr_c2", c_CNT_WR ? 32'd1 : 32'd48);
      tick();
      irq_chk("cntwr_irq", c_CNT_WR);
      wr(2'd0, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire

// File: doc/timer_irq.md
# timer_irq

Memory-mapped countdown timer that acts as the interrupt source on the far side of the coprocessor-0 interrupt path. It drives one bit of the CPU's 6-bit `HW_Int` bus, by convention `HW_Int[0]`. The CPU programs it through the peripheral bridge (loads/stores to a 3-word register window). When the count expires, it raises `IRQ`, either as a held level (mode 0) or as a one-cycle pulse with auto-reload (mode 1).

## Interface
- `CNT_W`, default 32: width of PRESET/COUNT (≤32); reads zero-extend to 32 bits.
- `clk` input, 1: system clock; all state changes on posedge.
- `reset` input, 1: synchronous, active-high; one clock and one synchronous active-high reset, as stated.
- `Addr` input, 30: word address `[31:2]`; only `Addr[3:2]` is decoded (0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = unmapped).
- `WE` input, 1: write enable for the addressed register.
- `Din` input, 32: write data.
- `Dout` output, 32: combinational read data for `Addr`; unmapped reads return 0.
- `IRQ` output, 1: interrupt request, equal to `CTRL.IM & irq_flag`.

## Operation
- CTRL fields:
  - `[0]` EN: counting enable.
  - `[2:1]` MODE: 0 = one-shot level, 1 = periodic pulse; 2 and 3 behave as 0.
  - `[3]` IM: interrupt mask.
  - `[31:4]` read as 0 and ignore writes.
- PRESET: reload value, read/write.
- COUNT: current value, read-only (see Configuration).
- FSM states:
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT ← PRESET; go to CNT.
  - CNT:
    - If !EN: go to IDLE; COUNT holds its value.
    - Else if COUNT > 1: COUNT ← COUNT−1.
    - Else (COUNT is 1 or 0): COUNT ← 0, irq_flag ← 1, go to INT.
  - INT:
    - Mode 0: EN ← 0; go to IDLE; irq_flag stays set.
    - Mode 1: irq_flag ← 0; go to IDLE; EN stays set, so the timer reloads.
- Any bus write to CTRL or PRESET clears irq_flag in that cycle.
- A PRESET write during CNT does not change COUNT; it takes effect at the next LOAD.
- Simultaneous bus write to CTRL and FSM clearing EN in INT: the bus write wins; CTRL takes `Din[3:0]`.
- Writing CTRL.EN = 0 during CNT freezes COUNT, and the FSM goes to IDLE next cycle. Re-enabling reloads from PRESET; there is no resume.
- Writes to address 3 (or to COUNT when the macro is off) are ignored.
- Reset (including mid-count): CTRL = 0, PRESET = 0, COUNT = 0, irq_flag = 0, state = IDLE, `IRQ` = 0.

## Timing
- `Dout` is combinational from the registers: the same-cycle read returns the value before that cycle's edge.
- Register writes are visible on `Dout` in the cycle after the `WE` edge.
- Mode 0, PRESET = P ≥ 1, CTRL written with EN = 1 at edge E:
  - IDLE at E+1, LOAD at E+2, CNT from E+3 (COUNT = P).
  - COUNT reaches 1 in the cycle after edge E+P+2.
  - irq_flag is visible after edge E+P+3.
  - `IRQ` rises P+3 cycles after the write edge and stays high until a CTRL/PRESET write.
- PRESET = 0 behaves as P = 1.
- Mode 1:
  - `IRQ` is high for exactly 1 cycle (INT state).
  - Period is P+3 cycles (CNT×P, INT, IDLE, LOAD).
- IM = 0 masks `IRQ` only; irq_flag still sets. Setting IM later raises `IRQ` on the next cycle if irq_flag is set and no clearing write occurs. A CTRL write itself clears irq_flag, so in practice enabling IM via CTRL never exposes an old flag.

## Configuration
- `TIMER_COUNT_WRITE_EN`:
  - Defined: a write to COUNT (Addr[3:2] = 2) loads `Din[CNT_W-1:0]` into COUNT in any state. It takes priority over the FSM decrement/reload in that cycle, does not change state, and does not clear irq_flag.
  - Undefined: COUNT is read-only and such writes are dropped.

## Test plan
- Reset → `Dout` = 0 for addrs 0/1/2; `IRQ` = 0. Write PRESET = 5, then read → 5.
- Mode 0, IM = 1, PRESET = 5, write CTRL = 0x9:
  - `IRQ` rises 8 cycles after the write edge and holds.
  - CTRL reads 0x8 (EN cleared).
  - A subsequent PRESET write drops `IRQ` next cycle.
- Mode 1, IM = 1, PRESET = 3, CTRL = 0xB → `IRQ` one-cycle pulses every 6 cycles; COUNT reads sequence 3, 2, 1, 0, 0, 0, 3…
- Masking: mode 0, IM = 0, PRESET = 2, CTRL = 0x1 → `IRQ` stays 0 after expiry; CTRL reads 0x0.
- Mid-count disable and reset: PRESET = 10, CTRL = 0x1; after COUNT reads 6, write CTRL = 0 → COUNT holds 6. Re-enable → COUNT reloads 10. Assert `reset` mid-count → all reads 0, `IRQ` = 0 next cycle.
- With `TIMER_COUNT_WRITE_EN`: during CNT with COUNT = 50, write COUNT = 2 → reads 2 next cycle, then 1, then INT fires. Without the macro the same write is ignored.
